// File: rtl/mips_cpu_harvard_mult_div.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// MULT/MULTU use MSB-first shift-add; DIV/DIVU use restoring shift-subtract
// on magnitudes, with sign correction applied in a final FIX cycle.
module mips_cpu_harvard_mult_div #(
  parameter int ITERATIONS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t      state;
  logic [4:0]  count;
  logic [63:0] acc;      // product, or {remainder, quotient/dividend}
  logic [31:0] opnd;     // |multiplicand| or |divisor|
  logic [31:0] mulr;     // |multiplier|
  logic [31:0] a_orig;   // un-abs'd dividend for divide-by-zero
  logic        is_div;
  logic        neg_q;    // negate product / quotient
  logic        neg_r;    // negate remainder
  logic        div0;

  logic        is_signed;
  logic [31:0] a_abs, b_abs;
  logic [32:0] trial;
  logic        ge;
  logic [63:0] mul_res;
  logic [31:0] q_res, r_res;

  // Operand magnitudes, divide trial step and sign-corrected results.
  // NOTE: every always_comb output is defaulted first so no latch is inferred.
  always_comb begin
    is_signed = (md_op == OP_MULT) || (md_op == OP_DIV);
    a_abs     = (is_signed && A[31]) ? -A : A;
    b_abs     = (is_signed && B[31]) ? -B : B;
    trial     = acc[63:31];
    ge        = trial >= {1'b0, opnd};
    mul_res   = neg_q ? -acc : acc;
    q_res     = neg_q ? -acc[31:0] : acc[31:0];
    r_res     = neg_r ? -acc[63:32] : acc[63:32];
  end

  // Control FSM plus datapath; every output is a register.
  // NOTE: sequential state uses non-blocking assignments only, so all
  // registers update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      acc    <= '0;
      opnd   <= '0;
      mulr   <= '0;
      a_orig <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (md_op <= 3'd3) begin
              is_div <= md_op[1];
              a_orig <= A;
              div0   <= md_op[1] && (B == 32'd0);
              neg_q  <= is_signed && (A[31] ^ B[31]);
              neg_r  <= is_signed && A[31];
              count  <= 5'(ITERATIONS - 1);
              if (md_op[1]) begin
                acc  <= {32'd0, a_abs};
                opnd <= b_abs;
              end else begin
                acc  <= '0;
                opnd <= a_abs;
              end
              mulr  <= b_abs;
              busy  <= 1'b1;
              state <= CALC;
            end else if (md_op == OP_MTHI) begin
              hi <= A;
            end else if (md_op == OP_MTLO) begin
              lo <= A;
            end
          end
        end
        CALC: begin
          if (is_div) begin
            if (ge) acc <= {32'(trial - {1'b0, opnd}), acc[30:0], 1'b1};
            else    acc <= {trial[31:0], acc[30:0], 1'b0};
          end else begin
            acc <= {acc[62:0], 1'b0} + (mulr[count] ? {32'd0, opnd} : 64'd0);
          end
          count <= count - 5'd1;
          if (count == 5'd0) state <= FIX;
        end
        FIX: begin
          if (!is_div) begin
            hi <= mul_res[63:32];
            lo <= mul_res[31:0];
          end else if (div0) begin
            hi <= a_orig;
            lo <= 32'hFFFF_FFFF;
          end else begin
            hi <= r_res;
            lo <= q_res;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_harvard_mult_div.sv
// Self-checking bench for the multiply/divide unit: directed corner cases
// plus randomized operations checked against an arithmetic reference model.
module tb_mips_cpu_harvard_mult_div;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_hi, exp_lo;

  mips_cpu_harvard_mult_div dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .A(A), .B(B), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {hi, lo} from plain 64-bit arithmetic on the operand values.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = 64'(sa * sb); return p; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; return p; end
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {32'(r), 32'(q)};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Issue a mult/div op, optionally disturb inputs mid-CALC, check latency and result.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb);
    int cyc;
    logic [63:0] r;
    r = model(op, a, b);
    start = 1'b1; md_op = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      if (disturb && cyc == 5) begin
        start = 1'b1; md_op = 3'd5; A = $urandom; B = $urandom;
      end else if (disturb && cyc == 6) begin
        start = 1'b0; A = $urandom; B = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_cycles", 64'(cyc), 64'd33);
    check("done_pulse", 64'(done), 64'd1);
    check($sformatf("result op%0d a=%h b=%h", op, a, b), {hi, lo}, r);
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    @(negedge clk);
    check("done_low", 64'(done), 64'd0);
  endtask

  // MTHI/MTLO/reserved ops in IDLE: one edge, no busy/done.
  task automatic run_move(input logic [2:0] op, input logic [31:0] a);
    start = 1'b1; md_op = op; A = a; B = $urandom;
    @(negedge clk);
    start = 1'b0;
    if (op == 3'd4) exp_hi = a;
    if (op == 3'd5) exp_lo = a;
    check($sformatf("move op%0d busy", op), 64'(busy), 64'd0);
    check($sformatf("move op%0d done", op), 64'(done), 64'd0);
    check($sformatf("move op%0d hilo", op), {hi, lo}, {exp_hi, exp_lo});
    @(negedge clk);
    check($sformatf("move op%0d busy2", op), 64'(busy), 64'd0);
  endtask

  initial begin
    int cyc;
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    reset = 1'b1; start = 1'b0; md_op = '0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hilo", {hi, lo}, 64'd0);
    exp_hi = 0; exp_lo = 0;

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("multu max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 0);
    check("mult -3*7", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    check("div -7/2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd3, 32'd100, 32'd0, 0);
    check("divu by 0", {hi, lo}, {32'd100, 32'hFFFF_FFFF});
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div overflow", {hi, lo}, {32'd0, 32'h8000_0000});
    run_op(3'd2, 32'hFFFF_FFF9, 32'd0, 0);
    check("div by 0 signed", {hi, lo}, {32'hFFFF_FFF9, 32'hFFFF_FFFF});

    run_move(3'd4, 32'h1234_5678);
    run_move(3'd5, 32'hCAFE_F00D);
    check("mthi/mtlo", {hi, lo}, 64'h1234_5678_CAFE_F00D);
    run_move(3'd6, 32'hDEAD_BEEF);
    run_move(3'd7, 32'hBEEF_DEAD);

    run_op(3'd3, 32'd10, 32'd3, 1);
    check("divu 10/3 disturbed", {hi, lo}, {32'd1, 32'd3});

    // Reset on the 10th CALC cycle discards the in-flight operation.
    start = 1'b1; md_op = 3'd1; A = 32'hFFFF_0000; B = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin @(negedge clk); cyc++; end
    check("busy before reset", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midop reset busy", 64'(busy), 64'd0);
    check("midop reset done", 64'(done), 64'd0);
    check("midop reset hilo", {hi, lo}, 64'd0);
    run_op(3'd1, 32'd6, 32'd7, 0);
    check("multu 6*7", {hi, lo}, 64'd42);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) rb = -rb;
      run_op(rop, ra, rb, bit'($urandom_range(0, 1)));
      if (i % 8 == 0) run_move(3'(4 + (i / 8) % 2), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
